ad9434_cap_sched: RTL and testbench
===================================

Name: ad9434_cap_sched

Overview:
- Capture sequencer for the AD9434 acquisition path, in the DataMover clock domain.
- Owns the S2MM command and status channels; ad9434_data keeps only the S2MM data stream.
- Per capture: issues a DataMover write command into a ring of DDR buffers, triggers ad9434_data, waits for capture completion and S2MM status, then advances the buffer.
- Supports a fixed number of back-to-back captures or free-running mode until stopped.

Parameters:
- BUF_NUM, 4, number of DDR ring buffers (power of 2, 2..16).
- BUF_BASE, 32'h1000_0000, byte address of buffer 0.
- BUF_STRIDE, 32'h0010_0000, byte distance between buffers; must be >= 1023*BYTES_PER_US.
- BYTES_PER_US, 800, S2MM bytes produced per microsecond of capture.
- TRIG_W, 4, o_trig pulse width in dm_clk cycles (wide enough for the CDC into clk_200m).
- TO_CYCLES, 1_000_000, timeout in the wait states.

Ports:
- dm_clk  in  1  DataMover clock; the only clock.
- dm_rst_n  in  1  asynchronous active-low reset.
- i_start  in  1  one-cycle start pulse; ignored unless IDLE.
- i_stop  in  1  one-cycle stop request.
- i_clr_err  in  1  one-cycle pulse; leaves ERR.
- i_num_caps  in  16  captures per run; 0 = unlimited.
- i_us_capture  in  10  capture length in us; also forwarded to ad9434_data.
- o_trig  out  1  capture trigger to ad9434_data.
- i_cap_done  in  1  capture-done level/pulse from ad9434_data, already synchronised to dm_clk.
- o_s2mm_wr_cmd_tdata  out  72  DataMover command.
- o_s2mm_wr_cmd_tvalid  out  1  command valid.
- i_s2mm_wr_cmd_tready  in  1  command ready.
- i_s2mm_sts_tdata  in  8  DataMover status.
- i_s2mm_sts_tvalid  in  1  status valid.
- o_s2mm_sts_tready  out  1  status ready.
- o_busy  out  1  high whenever state is not IDLE.
- o_buf_idx  out  $clog2(BUF_NUM)  buffer currently being filled.
- o_cap_cnt  out  16  captures completed in the current run.
- o_err  out  1  sticky error flag.
- o_err_code  out  3  1 = bad config, 2 = done timeout, 3 = status timeout, 4 = tag mismatch, 5 = DataMover error bits.
- o_irq  out  1  one-cycle pulse at normal run end.

Behaviour:
- Reset: all outputs 0, state IDLE, buf_idx 0, stop request cleared, counters 0.
- Start (IDLE, i_start=1):
  - Latch i_num_caps and i_us_capture; clear cap_cnt and buf_idx.
  - If latched us_capture == 0: go to ERR with code 1.
  - i_start and i_stop in the same cycle: start ignored.
- BTT: registered once at start as us_capture*BYTES_PER_US, 23 bits, unsigned; no overflow for legal parameters.
- Command fields:
  - [22:0] BTT; [23] = 1 (INCR); [29:24] = 0; [30] EOF = 1; [31] DRR = 0.
  - [63:32] = BUF_BASE + buf_idx*BUF_STRIDE; [67:64] tag = cap_cnt[3:0]; [71:68] = 0.
- FSM:
  - IDLE: wait for start.
  - CMD: tvalid=1 with data stable; on tvalid&tready go to TRIG. No timeout here.
  - TRIG: o_trig=1 for exactly TRIG_W cycles; then go to WAIT_DONE.
  - WAIT_DONE: wait for a rising edge of i_cap_done (edge-detected against a registered copy); go to WAIT_STS. Timeout gives code 2.
  - WAIT_STS: sts_tready=1.
    - On tvalid, check tag == expected, OKAY bit [7] = 1 and bits [6:4] = 0.
    - Any error bit gives code 5. Tag mismatch with no error bits gives code 4.
    - Otherwise go to NEXT. Timeout gives code 3.
  - NEXT: one cycle. cap_cnt+1; buf_idx+1, wrapping BUF_NUM-1 to 0.
    - If stop request set, or num_caps != 0 and the new cap_cnt == num_caps: go to IDLE and pulse o_irq.
    - Otherwise go to CMD.
    - cap_cnt saturates at 16'hFFFF in unlimited mode.
  - ERR: o_err=1, o_err_code held, o_s2mm_sts_tready=1 to drain stale status. On i_clr_err go to IDLE and clear err/code.
- Stop request:
  - i_stop while busy sets a sticky request; the current capture completes fully, then the run ends at NEXT with o_irq.
  - i_stop in IDLE or ERR has no effect.
  - The request clears on entry to IDLE.
- Timeout counter: reset on every state change; error when it reaches TO_CYCLES-1.
- Interrupt: no o_irq on error exit. o_irq and o_busy fall in the same cycle.
- Outside CMD, tvalid = 0; outside WAIT_STS and ERR, sts_tready = 0.

Decomposition:
- Package ad9434_pkg:
  - state enum, err_code enum;
  - DataMover command struct (btt, type, dsa, eof, drr, saddr, tag, rsvd) and status struct;
  - constants CMD_W = 72, STS_W = 8.
- Sub-module ad9434_dm_cmd_pack: combinational packing of struct fields into the 72-bit command.
- Timeout counter and edge detector stay inline.

Test Plan:
- Single run, basic command: num_caps=1, us=2, cmd_tready=1, done 50 cycles after trig, status 8'h80.
  - Command = {4'h0, tag 0, 32'h1000_0000, 1'b0, 1'b1, 6'h0, 1'b1, 23'd1600}.
  - o_trig high 4 cycles; o_irq once; cap_cnt=1; buf_idx=1.
- Ring wrap: num_caps=6, status tags 0..5 OKAY.
  - Addresses 1000_0000, 1010_0000, 1020_0000, 1030_0000, 1000_0000, 1010_0000.
  - Final buf_idx=2.
- Backpressure and stop: cmd_tready=0 for 20 cycles, then 1; tvalid and data held stable.
  - Unlimited mode with i_stop during the 3rd WAIT_DONE: 3rd capture completes, cap_cnt=3, o_irq.
- Status errors: status 8'h41 on capture 0 gives err_code 5. Status 8'h83 for expected tag 0 gives code 4.
  - i_clr_err returns to IDLE; a new start works.
- Timeouts and bad config: withhold cap_done TO_CYCLES cycles gives code 2. us=0 at start gives code 1 with no command issued.
- Reset mid-run: assert dm_rst_n low during WAIT_STS; all outputs 0 asynchronously, state IDLE after release.

Source files
------------

// File: rtl/ad9434_pkg.sv
// Shared types and helpers for the AD9434 capture sequencer: FSM states,
// error codes, DataMover command/status layouts and small helper functions.
package ad9434_pkg;

   localparam int CMD_W = 72;
   localparam int STS_W = 8;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_CMD       = 3'd1,
      ST_TRIG      = 3'd2,
      ST_WAIT_DONE = 3'd3,
      ST_WAIT_STS  = 3'd4,
      ST_NEXT      = 3'd5,
      ST_ERR       = 3'd6
   } state_e;

   typedef enum logic [2:0] {
      ERR_NONE    = 3'd0,
      ERR_CFG     = 3'd1,
      ERR_DONE_TO = 3'd2,
      ERR_STS_TO  = 3'd3,
      ERR_TAG     = 3'd4,
      ERR_DM      = 3'd5
   } err_code_e;

   // S2MM command word, MSB first: rsvd, tag, saddr, drr, eof, dsa, type, btt.
   typedef struct packed {
      logic [3:0]  rsvd;
      logic [3:0]  tag;
      logic [31:0] saddr;
      logic        drr;
      logic        eof;
      logic [5:0]  dsa;
      logic        cmd_type;
      logic [22:0] btt;
   } dm_cmd_t;

   // S2MM status byte: OKAY, SLVERR, DECERR, INTERR, tag.
   typedef struct packed {
      logic       okay;
      logic       slverr;
      logic       decerr;
      logic       interr;
      logic [3:0] tag;
   } dm_sts_t;

   // Start address of ring buffer idx.
   function automatic logic [31:0] buf_addr(input logic [31:0] base,
                                            input logic [31:0] stride,
                                            input logic [3:0]  idx);
      return base + ({28'd0, idx} * stride);
   endfunction

   // A status is bad when OKAY is missing or any error bit is set.
   function automatic logic sts_has_error(input dm_sts_t sts);
      return (!sts.okay) || sts.slverr || sts.decerr || sts.interr;
   endfunction

endpackage

// File: rtl/ad9434_dm_cmd_pack.sv
// Packs the variable fields of one capture into a 72-bit S2MM write command
// (single INCR transfer, EOF set, no realignment).
module ad9434_dm_cmd_pack
   import ad9434_pkg::*;
(
   input  logic [22:0]      btt_i,
   input  logic [31:0]      saddr_i,
   input  logic [3:0]       tag_i,
   output logic [CMD_W-1:0] cmd_o
);

   dm_cmd_t cmd_s;

   // Fill the command struct; fixed fields are constants.
   always_comb begin
      cmd_s          = '0;
      cmd_s.btt      = btt_i;
      cmd_s.cmd_type = 1'b1;
      cmd_s.dsa      = 6'd0;
      cmd_s.eof      = 1'b1;
      cmd_s.drr      = 1'b0;
      cmd_s.saddr    = saddr_i;
      cmd_s.tag      = tag_i;
      cmd_s.rsvd     = 4'd0;
   end

   assign cmd_o = cmd_s;

endmodule

// File: rtl/ad9434_cap_sched.sv
// AD9434 capture sequencer (DataMover clock domain): per capture it issues an
// S2MM write command into a ring of DDR buffers, triggers the data path, waits
// for capture done and S2MM status, then advances the buffer.
module ad9434_cap_sched
   import ad9434_pkg::*;
#(
   parameter int unsigned   BUF_NUM      = 4,
   parameter logic [31:0]   BUF_BASE     = 32'h1000_0000,
   parameter logic [31:0]   BUF_STRIDE   = 32'h0010_0000,
   parameter int unsigned   BYTES_PER_US = 800,
   parameter int unsigned   TRIG_W       = 4,
   parameter int unsigned   TO_CYCLES    = 1_000_000,
   localparam int unsigned  BIW          = $clog2(BUF_NUM)
) (
   input  logic             dm_clk,
   input  logic             dm_rst_n,
   input  logic             i_start,
   input  logic             i_stop,
   input  logic             i_clr_err,
   input  logic [15:0]      i_num_caps,
   input  logic [9:0]       i_us_capture,
   output logic             o_trig,
   input  logic             i_cap_done,
   output logic [CMD_W-1:0] o_s2mm_wr_cmd_tdata,
   output logic             o_s2mm_wr_cmd_tvalid,
   input  logic             i_s2mm_wr_cmd_tready,
   input  logic [STS_W-1:0] i_s2mm_sts_tdata,
   input  logic             i_s2mm_sts_tvalid,
   output logic             o_s2mm_sts_tready,
   output logic             o_busy,
   output logic [BIW-1:0]   o_buf_idx,
   output logic [15:0]      o_cap_cnt,
   output logic             o_err,
   output logic [2:0]       o_err_code,
   output logic             o_irq
);

   // Counter must also cover the trigger width, which reuses it.
   localparam int unsigned TO_W = $clog2(TO_CYCLES + TRIG_W);

   state_e          state_q, state_d;
   err_code_e       err_code_q, err_code_d;
   logic [TO_W-1:0] cnt_q, cnt_d;
   logic            stop_q, stop_d;
   logic [15:0]     num_caps_q, num_caps_d;
   logic [22:0]     btt_q, btt_d;
   logic [BIW-1:0]  buf_idx_q, buf_idx_d;
   logic [15:0]     cap_cnt_q, cap_cnt_d;
   logic            irq_d;
   logic            done_q;
   logic            trig_q, cmd_tvalid_q, sts_tready_q, busy_q, err_q, irq_q;
   logic [CMD_W-1:0] cmd_data_q;

   logic             cap_rise_s;
   logic             to_hit_s;
   logic             trig_last_s;
   dm_sts_t          sts_s;
   logic [31:0]      saddr_s;
   logic [CMD_W-1:0] cmd_pack_s;

   assign cap_rise_s  = i_cap_done & ~done_q;
   assign to_hit_s    = (cnt_q == TO_W'(TO_CYCLES - 1));
   assign trig_last_s = (cnt_q == TO_W'(TRIG_W - 1));
   assign sts_s       = i_s2mm_sts_tdata;
   assign saddr_s     = buf_addr(BUF_BASE, BUF_STRIDE, 4'(buf_idx_d));

   // Command is built from next-state fields so it is registered together with tvalid.
   ad9434_dm_cmd_pack u_cmd_pack (
      .btt_i   (btt_d),
      .saddr_i (saddr_s),
      .tag_i   (cap_cnt_d[3:0]),
      .cmd_o   (cmd_pack_s)
   );

   // FSM next state, run bookkeeping and error capture.
   always_comb begin
      state_d    = state_q;
      num_caps_d = num_caps_q;
      btt_d      = btt_q;
      buf_idx_d  = buf_idx_q;
      cap_cnt_d  = cap_cnt_q;
      err_code_d = err_code_q;
      irq_d      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (i_start && !i_stop) begin
               num_caps_d = i_num_caps;
               btt_d      = 23'(i_us_capture * BYTES_PER_US);
               cap_cnt_d  = 16'd0;
               buf_idx_d  = '0;
               if (i_us_capture == 10'd0) begin
                  state_d    = ST_ERR;
                  err_code_d = ERR_CFG;
               end else begin
                  state_d = ST_CMD;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_CMD: begin
            if (cmd_tvalid_q && i_s2mm_wr_cmd_tready) begin
               state_d = ST_TRIG;
            end else begin
               state_d = ST_CMD;
            end
         end
         ST_TRIG: begin
            if (trig_last_s) begin
               state_d = ST_WAIT_DONE;
            end else begin
               state_d = ST_TRIG;
            end
         end
         ST_WAIT_DONE: begin
            if (cap_rise_s) begin
               state_d = ST_WAIT_STS;
            end else if (to_hit_s) begin
               state_d    = ST_ERR;
               err_code_d = ERR_DONE_TO;
            end else begin
               state_d = ST_WAIT_DONE;
            end
         end
         ST_WAIT_STS: begin
            if (sts_tready_q && i_s2mm_sts_tvalid) begin
               if (sts_has_error(sts_s)) begin
                  state_d    = ST_ERR;
                  err_code_d = ERR_DM;
               end else if (sts_s.tag != cap_cnt_q[3:0]) begin
                  state_d    = ST_ERR;
                  err_code_d = ERR_TAG;
               end else begin
                  state_d = ST_NEXT;
               end
            end else if (to_hit_s) begin
               state_d    = ST_ERR;
               err_code_d = ERR_STS_TO;
            end else begin
               state_d = ST_WAIT_STS;
            end
         end
         ST_NEXT: begin
            cap_cnt_d = (cap_cnt_q == 16'hFFFF) ? 16'hFFFF : (cap_cnt_q + 16'd1);
            buf_idx_d = buf_idx_q + BIW'(1);
            if (stop_q || ((num_caps_q != 16'd0) && (cap_cnt_d == num_caps_q))) begin
               state_d = ST_IDLE;
               irq_d   = 1'b1;
            end else begin
               state_d = ST_CMD;
            end
         end
         ST_ERR: begin
            if (i_clr_err) begin
               state_d    = ST_IDLE;
               err_code_d = ERR_NONE;
            end else begin
               state_d = ST_ERR;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Sticky stop request: armed only mid-run, dropped whenever the run returns to IDLE.
   always_comb begin
      if (state_d == ST_IDLE) begin
         stop_d = 1'b0;
      end else if (i_stop && (state_q != ST_IDLE) && (state_q != ST_ERR)) begin
         stop_d = 1'b1;
      end else begin
         stop_d = stop_q;
      end
   end

   // Shared wait/trigger counter, restarted on every state change.
   always_comb begin
      if (state_d != state_q) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + TO_W'(1);
      end
   end

   // State, run registers and registered outputs decoded from the next state.
   always_ff @(posedge dm_clk or negedge dm_rst_n) begin
      if (!dm_rst_n) begin
         state_q      <= ST_IDLE;
         err_code_q   <= ERR_NONE;
         cnt_q        <= '0;
         stop_q       <= 1'b0;
         num_caps_q   <= 16'd0;
         btt_q        <= 23'd0;
         buf_idx_q    <= '0;
         cap_cnt_q    <= 16'd0;
         done_q       <= 1'b0;
         trig_q       <= 1'b0;
         cmd_tvalid_q <= 1'b0;
         cmd_data_q   <= '0;
         sts_tready_q <= 1'b0;
         busy_q       <= 1'b0;
         err_q        <= 1'b0;
         irq_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         err_code_q   <= err_code_d;
         cnt_q        <= cnt_d;
         stop_q       <= stop_d;
         num_caps_q   <= num_caps_d;
         btt_q        <= btt_d;
         buf_idx_q    <= buf_idx_d;
         cap_cnt_q    <= cap_cnt_d;
         done_q       <= i_cap_done;
         trig_q       <= (state_d == ST_TRIG);
         cmd_tvalid_q <= (state_d == ST_CMD);
         cmd_data_q   <= (state_d == ST_CMD) ? cmd_pack_s : '0;
         sts_tready_q <= (state_d == ST_WAIT_STS) || (state_d == ST_ERR);
         busy_q       <= (state_d != ST_IDLE);
         err_q        <= (state_d == ST_ERR);
         irq_q        <= irq_d;
      end
   end

   assign o_trig               = trig_q;
   assign o_s2mm_wr_cmd_tdata  = cmd_data_q;
   assign o_s2mm_wr_cmd_tvalid = cmd_tvalid_q;
   assign o_s2mm_sts_tready    = sts_tready_q;
   assign o_busy               = busy_q;
   assign o_buf_idx            = buf_idx_q;
   assign o_cap_cnt            = cap_cnt_q;
   assign o_err                = err_q;
   assign o_err_code           = err_code_q;
   assign o_irq                = irq_q;

endmodule

// File: tb/tb_ad9434_cap_sched.sv
// Randomized scoreboard bench for ad9434_cap_sched: expected commands are
// queued by the stimulus side and popped by a monitor on each handshake.
module tb_ad9434_cap_sched;

   localparam int unsigned BUF_NUM = 4;
   localparam logic [31:0] BASE    = 32'h1000_0000;
   localparam logic [31:0] STRIDE  = 32'h0010_0000;
   localparam int unsigned BPU     = 800;
   localparam int unsigned TRIG_W  = 4;
   localparam int unsigned TO_CYC  = 300;

   localparam int SEL_TRIG = 0, SEL_NTRIG = 1, SEL_STSRDY = 2, SEL_ERR = 3,
                  SEL_HS = 4, SEL_IDLE = 5, SEL_TVALID = 6;

   logic        dm_clk = 1'b0;
   logic        dm_rst_n = 1'b0;
   logic        i_start = 1'b0, i_stop = 1'b0, i_clr_err = 1'b0;
   logic [15:0] i_num_caps = 16'd0;
   logic [9:0]  i_us_capture = 10'd0;
   logic        o_trig;
   logic        i_cap_done = 1'b0;
   logic [71:0] o_s2mm_wr_cmd_tdata;
   logic        o_s2mm_wr_cmd_tvalid;
   logic        i_s2mm_wr_cmd_tready = 1'b1;
   logic [7:0]  i_s2mm_sts_tdata = 8'd0;
   logic        i_s2mm_sts_tvalid = 1'b0;
   logic        o_s2mm_sts_tready;
   logic        o_busy;
   logic [1:0]  o_buf_idx;
   logic [15:0] o_cap_cnt;
   logic        o_err;
   logic [2:0]  o_err_code;
   logic        o_irq;

   int checks = 0;
   int failures = 0;
   logic [71:0] exp_q[$];
   int          cmd_hs_cnt = 0;
   int          irq_cnt = 0;
   logic        held_v = 1'b0;
   logic [71:0] held_d = 72'd0;

   ad9434_cap_sched #(
      .BUF_NUM(BUF_NUM), .BUF_BASE(BASE), .BUF_STRIDE(STRIDE),
      .BYTES_PER_US(BPU), .TRIG_W(TRIG_W), .TO_CYCLES(TO_CYC)
   ) dut (
      .dm_clk(dm_clk), .dm_rst_n(dm_rst_n),
      .i_start(i_start), .i_stop(i_stop), .i_clr_err(i_clr_err),
      .i_num_caps(i_num_caps), .i_us_capture(i_us_capture),
      .o_trig(o_trig), .i_cap_done(i_cap_done),
      .o_s2mm_wr_cmd_tdata(o_s2mm_wr_cmd_tdata),
      .o_s2mm_wr_cmd_tvalid(o_s2mm_wr_cmd_tvalid),
      .i_s2mm_wr_cmd_tready(i_s2mm_wr_cmd_tready),
      .i_s2mm_sts_tdata(i_s2mm_sts_tdata),
      .i_s2mm_sts_tvalid(i_s2mm_sts_tvalid),
      .o_s2mm_sts_tready(o_s2mm_sts_tready),
      .o_busy(o_busy), .o_buf_idx(o_buf_idx), .o_cap_cnt(o_cap_cnt),
      .o_err(o_err), .o_err_code(o_err_code), .o_irq(o_irq)
   );

   always #5 dm_clk = ~dm_clk;

   task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic sig_sel(input int sel);
      case (sel)
         SEL_TRIG:   return o_trig;
         SEL_NTRIG:  return !o_trig;
         SEL_STSRDY: return o_s2mm_sts_tready;
         SEL_ERR:    return o_err;
         SEL_HS:     return o_s2mm_wr_cmd_tvalid && i_s2mm_wr_cmd_tready;
         SEL_IDLE:   return !o_busy;
         SEL_TVALID: return o_s2mm_wr_cmd_tvalid;
         default:    return 1'b0;
      endcase
   endfunction

   // Bounded wait at negedges; an expired bound is a failed comparison.
   task automatic wait_for(input int sel, input string name, input int max);
      int n = 0;
      @(negedge dm_clk);
      while (!sig_sel(sel) && n < max) begin
         @(negedge dm_clk);
         n++;
      end
      check({"wait_", name}, 72'(sig_sel(sel)), 72'd1);
   endtask

   // Command scoreboard, stability under backpressure and irq monitor.
   always @(negedge dm_clk) begin
      if (!dm_rst_n) begin
         held_v = 1'b0;
      end else begin
         if (o_s2mm_wr_cmd_tvalid) begin
            if (held_v) check("cmd_stable", o_s2mm_wr_cmd_tdata, held_d);
            if (i_s2mm_wr_cmd_tready) begin
               cmd_hs_cnt++;
               check("cmd_expected", 72'(exp_q.size() != 0), 72'd1);
               if (exp_q.size() != 0) check("cmd_data", o_s2mm_wr_cmd_tdata, exp_q.pop_front());
            end
            held_v = !i_s2mm_wr_cmd_tready;
            held_d = o_s2mm_wr_cmd_tdata;
         end else begin
            held_v = 1'b0;
         end
         if (o_irq) begin
            irq_cnt++;
            check("irq_busy_low", 72'(o_busy), 72'd0);
         end
      end
   end

   task automatic start_run(input int n, input int us);
      @(posedge dm_clk); #1;
      i_num_caps = 16'(n); i_us_capture = 10'(us); i_start = 1'b1;
      @(posedge dm_clk); #1;
      i_start = 1'b0;
   endtask

   task automatic pulse_clr();
      @(posedge dm_clk); #1 i_clr_err = 1'b1;
      @(posedge dm_clk); #1 i_clr_err = 1'b0;
      wait_for(SEL_IDLE, "clr_idle", 10);
      check("clr_err_flag", 72'(o_err), 72'd0);
      check("clr_err_code", 72'(o_err_code), 72'd0);
   endtask

   // One capture: expected command from the address/tag/BTT rules, then the data-path responses.
   task automatic run_capture(input int k, input int us, input logic [7:0] sts, input int stall,
                              input bit stop_now, input bit give_done, input bit give_sts);
      logic [31:0] addr;
      logic [22:0] btt;
      logic [3:0]  tag;
      int n;
      addr = BASE + 32'(k % BUF_NUM) * STRIDE;
      btt  = 23'(us * BPU);
      tag  = 4'(k);
      exp_q.push_back({4'h0, tag, addr, 1'b0, 1'b1, 6'h0, 1'b1, btt});
      if (stall > 0) begin
         i_s2mm_wr_cmd_tready = 1'b0;
         wait_for(SEL_TVALID, "cmd_tvalid", 50);
         repeat (stall) @(posedge dm_clk);
         #1 i_s2mm_wr_cmd_tready = 1'b1;
      end
      wait_for(SEL_HS, "cmd_hs", 50);
      wait_for(SEL_TRIG, "trig", 10);
      n = 0;
      while (o_trig && n < 100) begin
         n++;
         @(negedge dm_clk);
      end
      check("trig_width", 72'(n), 72'(TRIG_W));
      if (stop_now) begin
         @(posedge dm_clk); #1 i_stop = 1'b1;
         @(posedge dm_clk); #1 i_stop = 1'b0;
      end
      if (give_done) begin
         repeat ($urandom_range(2, 20)) @(posedge dm_clk);
         #1 i_cap_done = 1'b1;
         @(posedge dm_clk); #1 i_cap_done = 1'b0;
         if (give_sts) begin
            repeat ($urandom_range(0, 5)) @(posedge dm_clk);
            #1 i_s2mm_sts_tdata = sts; i_s2mm_sts_tvalid = 1'b1;
            wait_for(SEL_STSRDY, "sts_ready", 50);
            @(posedge dm_clk); #1 i_s2mm_sts_tvalid = 1'b0;
         end
      end
   endtask

   function automatic logic [7:0] ok_sts(input int k);
      logic [3:0] t;
      t = 4'(k);
      return {4'b1000, t};
   endfunction

   task automatic end_of_run(input string name, input int irq0, input int caps);
      wait_for(SEL_IDLE, {name, "_idle"}, 50);
      @(negedge dm_clk);
      check({name, "_irq"}, 72'(irq_cnt - irq0), 72'd1);
      check({name, "_cap_cnt"}, 72'(o_cap_cnt), 72'(caps));
      check({name, "_buf_idx"}, 72'(o_buf_idx), 72'(caps % BUF_NUM));
   endtask

   initial begin
      int us;
      int irq0;
      int hs0;
      repeat (3) @(posedge dm_clk);
      #1;
      check("reset_outputs",
            {o_trig, o_s2mm_wr_cmd_tdata[63:0]} | 72'({o_s2mm_wr_cmd_tdata[71:64], o_s2mm_wr_cmd_tvalid,
             o_s2mm_sts_tready, o_busy, o_buf_idx, o_cap_cnt, o_err, o_err_code, o_irq}), 72'd0);
      dm_rst_n = 1'b1;

      // Single run, basic command.
      irq0 = irq_cnt;
      start_run(1, 2);
      run_capture(0, 2, 8'h80, 0, 1'b0, 1'b1, 1'b1);
      end_of_run("single", irq0, 1);

      // Ring wrap with random capture length and command stalls.
      irq0 = irq_cnt;
      us = $urandom_range(1, 1023);
      start_run(6, us);
      for (int k = 0; k < 6; k++) run_capture(k, us, ok_sts(k), $urandom_range(0, 3), 1'b0, 1'b1, 1'b1);
      end_of_run("wrap", irq0, 6);

      // Unlimited run, 20-cycle backpressure, stop during the third capture.
      irq0 = irq_cnt;
      us = $urandom_range(1, 1023);
      start_run(0, us);
      run_capture(0, us, ok_sts(0), 20, 1'b0, 1'b1, 1'b1);
      run_capture(1, us, ok_sts(1), 0, 1'b0, 1'b1, 1'b1);
      run_capture(2, us, ok_sts(2), 0, 1'b1, 1'b1, 1'b1);
      end_of_run("stop", irq0, 3);

      // DataMover error bits.
      irq0 = irq_cnt;
      start_run(1, 5);
      run_capture(0, 5, 8'h41, 0, 1'b0, 1'b1, 1'b1);
      wait_for(SEL_ERR, "err_dm", 10);
      check("err_dm_code", 72'(o_err_code), 72'd5);
      check("err_dm_busy", 72'(o_busy), 72'd1);
      pulse_clr();
      // Tag mismatch.
      start_run(1, 5);
      run_capture(0, 5, 8'h83, 0, 1'b0, 1'b1, 1'b1);
      wait_for(SEL_ERR, "err_tag", 10);
      check("err_tag_code", 72'(o_err_code), 72'd4);
      pulse_clr();
      check("err_no_irq", 72'(irq_cnt - irq0), 72'd0);

      // A new start after errors, preceded by an ignored stop in IDLE.
      @(posedge dm_clk); #1 i_stop = 1'b1;
      @(posedge dm_clk); #1 i_stop = 1'b0;
      irq0 = irq_cnt;
      us = $urandom_range(1, 1023);
      start_run(2, us);
      run_capture(0, us, ok_sts(0), 0, 1'b0, 1'b1, 1'b1);
      run_capture(1, us, ok_sts(1), 0, 1'b0, 1'b1, 1'b1);
      end_of_run("restart", irq0, 2);

      // Capture-done timeout.
      start_run(1, 3);
      run_capture(0, 3, 8'h80, 0, 1'b0, 1'b0, 1'b0);
      wait_for(SEL_ERR, "err_done_to", TO_CYC + 20);
      check("err_done_to_code", 72'(o_err_code), 72'd2);
      pulse_clr();

      // Status timeout.
      start_run(1, 3);
      run_capture(0, 3, 8'h80, 0, 1'b0, 1'b1, 1'b0);
      wait_for(SEL_ERR, "err_sts_to", TO_CYC + 20);
      check("err_sts_to_code", 72'(o_err_code), 72'd3);
      pulse_clr();

      // Zero capture length: config error, no command.
      hs0 = cmd_hs_cnt;
      start_run(1, 0);
      wait_for(SEL_ERR, "err_cfg", 10);
      check("err_cfg_code", 72'(o_err_code), 72'd1);
      check("err_cfg_no_cmd", 72'(cmd_hs_cnt - hs0), 72'd0);
      pulse_clr();

      // Start together with stop is ignored.
      @(posedge dm_clk); #1;
      i_num_caps = 16'd1; i_us_capture = 10'd4; i_start = 1'b1; i_stop = 1'b1;
      @(posedge dm_clk); #1 i_start = 1'b0; i_stop = 1'b0;
      @(negedge dm_clk);
      check("start_stop_ignored", 72'(o_busy), 72'd0);

      // Reset mid-run while waiting for status.
      start_run(1, 7);
      run_capture(0, 7, 8'h80, 0, 1'b0, 1'b1, 1'b0);
      wait_for(SEL_STSRDY, "rst_wait_sts", 10);
      #2 dm_rst_n = 1'b0;
      #1;
      check("async_reset_outputs",
            {o_trig, o_s2mm_wr_cmd_tdata[63:0]} | 72'({o_s2mm_wr_cmd_tdata[71:64], o_s2mm_wr_cmd_tvalid,
             o_s2mm_sts_tready, o_busy, o_buf_idx, o_cap_cnt, o_err, o_err_code, o_irq}), 72'd0);
      @(posedge dm_clk); #1 dm_rst_n = 1'b1;
      repeat (2) @(negedge dm_clk);
      check("after_reset_idle", 72'({o_busy, o_s2mm_sts_tready, o_s2mm_wr_cmd_tvalid}), 72'd0);

      check("scoreboard_empty", 72'(exp_q.size()), 72'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Global time limit.
   initial begin
      #2_000_000;
      failures++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
